// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the PE array psum outputs, the accumulator and the
// writeback stage.
//
// Valid/ready semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. The source holds valid and its
// payload stable until that edge. ready may be driven without looking at
// valid. valid while ready is low transfers nothing and is not remembered.
//
// Signals
//   psum_valid / psum_ready / psum / psum_last : input beat channel
//   out_valid / out_ready / out_data / out_overflow : result channel
// Modports
//   master : the side feeding beats and consuming results
//   slave  : the accumulator
interface psum_accumulator_if #(
    parameter int Size      = 9,
    parameter int PsumWidth = 16,
    parameter int AccWidth  = 24
);
    logic                      psum_valid;
    logic                      psum_ready;
    logic [Size*PsumWidth-1:0] psum;
    logic                      psum_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [AccWidth-1:0]       out_data;
    logic                      out_overflow;

    modport master (
        output psum_valid, psum, psum_last, out_ready,
        input  psum_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  psum_valid, psum, psum_last, out_ready,
        output psum_ready, out_valid, out_data, out_overflow
    );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator for the matrix_mul datapath.
// A registered adder tree reduces Size unsigned lane psums per beat; the tree
// output is summed over time into one AccWidth result per pass, the pass being
// closed by a beat carrying psum_last. Overflow either clamps to all-ones
// (Saturate=1) or wraps (Saturate=0), and a sticky flag reports it per pass.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   bus        : psum_accumulator_if.slave (input beats, output results)
//   busy       : high while draining the tree or holding a result
//   state_dbg  : current FSM state (debug)
module psum_accumulator #(
    parameter int Size      = 9,
    parameter int DataWidth = 8,
    parameter int PsumWidth = DataWidth * 2,
    parameter int AccWidth  = PsumWidth + 8,
    parameter bit Saturate  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    psum_accumulator_if.slave    bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int TreeDepth = $clog2(Size);
    localparam int TreeOutW  = PsumWidth + TreeDepth;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Node count after level k; level_nodes(-1) yields Size (the raw lanes).
    function automatic int level_nodes(input int k);
        return (Size + (1 << (k + 1)) - 1) >> (k + 1);
    endfunction

    logic beat_fire;
    assign beat_fire = bus.psum_valid && bus.psum_ready;

    // Adder tree: one register stage per level, pairs summed, an odd leftover
    // element is registered through unchanged. Valid/last ride alongside and
    // the tree never stalls, since input is stopped while it drains.
    for (genvar k = 0; k < TreeDepth; k++) begin : g_lvl
        localparam int NumIn  = level_nodes(k - 1);
        localparam int NumOut = level_nodes(k);
        localparam int WIn    = PsumWidth + k;
        localparam int WOut   = PsumWidth + k + 1;

        logic [WIn-1:0]  src   [NumIn];
        logic [WOut-1:0] sum_c [NumOut];
        logic [WOut-1:0] node  [NumOut];
        logic            src_vld, src_lst;
        logic            vld, lst;

        if (k == 0) begin : g_src
            for (genvar i = 0; i < Size; i++) begin : g_lane
                assign src[i] = bus.psum[i*PsumWidth +: PsumWidth];
            end
            assign src_vld = beat_fire;
            assign src_lst = bus.psum_last;
        end else begin : g_src
            for (genvar i = 0; i < NumIn; i++) begin : g_lane
                assign src[i] = g_lvl[k-1].node[i];
            end
            assign src_vld = g_lvl[k-1].vld;
            assign src_lst = g_lvl[k-1].lst;
        end

        for (genvar j = 0; j < NumOut; j++) begin : g_node
            if (2 * j + 1 < NumIn) begin : g_add
                assign sum_c[j] = WOut'(src[2*j]) + WOut'(src[2*j+1]);
            end else begin : g_pass
                assign sum_c[j] = WOut'(src[2*j]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld <= 1'b0;
                lst <= 1'b0;
            end else begin
                vld <= src_vld;
                lst <= src_vld && src_lst;
            end
            node <= sum_c;
        end
    end

    logic [TreeOutW-1:0] tree_sum;
    logic                tree_vld, tree_lst;
    assign tree_sum = g_lvl[TreeDepth-1].node[0];
    assign tree_vld = g_lvl[TreeDepth-1].vld;
    assign tree_lst = g_lvl[TreeDepth-1].lst;

    logic [AccWidth-1:0] acc;
    logic                ovf;
    logic                first;
    logic [AccWidth:0]   acc_sum;

    // One extra bit so the carry-out marks overflow of this add.
    assign acc_sum = {1'b0, acc} + (AccWidth + 1)'(tree_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (beat_fire && bus.psum_last) state_d = DRAIN;
            DRAIN:   if (tree_vld && tree_lst)       state_d = OUT;
            OUT:     if (bus.out_ready)              state_d = ACCUM;
            default:                                 state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (state_q == OUT && bus.out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (tree_vld) begin
            first <= 1'b0;
            if (first) begin
                acc <= AccWidth'(tree_sum);
            end else if (acc_sum[AccWidth]) begin
                // An all-ones acc carries on any non-zero add, so a clamped
                // pass stays clamped.
                ovf <= 1'b1;
                acc <= Saturate ? {AccWidth{1'b1}} : acc_sum[AccWidth-1:0];
            end else begin
                acc <= acc_sum[AccWidth-1:0];
            end
        end
    end

    assign bus.psum_ready   = (state_q == ACCUM);
    assign bus.out_valid    = (state_q == OUT);
    assign bus.out_data     = acc;
    assign bus.out_overflow = ovf;
    assign busy             = (state_q != ACCUM);
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: three instances (24-bit saturating, 20-bit
// saturating, 20-bit wrapping) see identical stimulus; a pass-level model
// predicts each instance's result and overflow flag.
module tb_psum_accumulator;
    localparam int SZ    = 9;
    localparam int PW    = 16;
    localparam int AW    = 24;
    localparam int AW20  = 20;
    localparam int BW    = SZ * PW;
    localparam int EXP_W = AW + 1 + AW20 + 1 + AW20 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [BW-1:0] in_psum = '0;
    logic          out_ready = 1'b1;
    logic          busy_m, busy_s, busy_w;
    logic [1:0]    st_m, st_s, st_w;

    int checks = 0;
    int errors = 0;

    longint             beat_sums[$];
    logic [EXP_W-1:0]   exp_q[$];

    psum_accumulator_if #(.Size(SZ), .PsumWidth(PW), .AccWidth(AW))   bus();
    psum_accumulator_if #(.Size(SZ), .PsumWidth(PW), .AccWidth(AW20)) bus_s20();
    psum_accumulator_if #(.Size(SZ), .PsumWidth(PW), .AccWidth(AW20)) bus_w20();

    assign bus.psum_valid     = in_valid;
    assign bus.psum           = in_psum;
    assign bus.psum_last      = in_last;
    assign bus.out_ready      = out_ready;
    assign bus_s20.psum_valid = in_valid;
    assign bus_s20.psum       = in_psum;
    assign bus_s20.psum_last  = in_last;
    assign bus_s20.out_ready  = out_ready;
    assign bus_w20.psum_valid = in_valid;
    assign bus_w20.psum       = in_psum;
    assign bus_w20.psum_last  = in_last;
    assign bus_w20.out_ready  = out_ready;

    psum_accumulator #(.Size(SZ), .DataWidth(8), .PsumWidth(PW), .AccWidth(AW), .Saturate(1'b1))
        u_dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy_m), .state_dbg(st_m));
    psum_accumulator #(.Size(SZ), .DataWidth(8), .PsumWidth(PW), .AccWidth(AW20), .Saturate(1'b1))
        u_sat20 (.clk(clk), .rst(rst), .bus(bus_s20), .busy(busy_s), .state_dbg(st_s));
    psum_accumulator #(.Size(SZ), .DataWidth(8), .PsumWidth(PW), .AccWidth(AW20), .Saturate(1'b0))
        u_wrap20 (.clk(clk), .rst(rst), .bus(bus_w20), .busy(busy_w), .state_dbg(st_w));

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void fold_pass(input int width, input bit sat,
                                      output logic [63:0] data, output logic ovf);
        longint mx;
        longint acc;
        mx  = (longint'(1) << width) - 1;
        acc = 0;
        ovf = 1'b0;
        foreach (beat_sums[i]) begin
            if (i == 0) begin
                acc = beat_sums[i];
            end else begin
                acc = acc + beat_sums[i];
                if (acc > mx) begin
                    ovf = 1'b1;
                    acc = sat ? mx : (acc & mx);
                end
            end
        end
        data = acc;
    endfunction

    task automatic model_accept(input logic [BW-1:0] d, input bit last);
        longint s;
        logic [63:0] d24, ds, dw;
        logic o24, os, ow;
        s = 0;
        for (int i = 0; i < SZ; i++) s += longint'(d[i*PW +: PW]);
        beat_sums.push_back(s);
        if (last) begin
            fold_pass(AW, 1'b1, d24, o24);
            fold_pass(AW20, 1'b1, ds, os);
            fold_pass(AW20, 1'b0, dw, ow);
            exp_q.push_back({d24[AW-1:0], o24, ds[AW20-1:0], os, dw[AW20-1:0], ow});
            beat_sums.delete();
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [BW-1:0] make_beat(input int mode, input int val);
        logic [BW-1:0] b;
        logic [PW-1:0] lane;
        b = '0;
        for (int i = 0; i < SZ; i++) begin
            case (mode)
                0:       lane = PW'(val);
                1:       lane = PW'($urandom_range(0, 65535));
                default: lane = PW'($urandom_range(0, 40));
            endcase
            b[i*PW +: PW] = lane;
        end
        return b;
    endfunction

    // Present one beat for one cycle; it is accepted only if ready is high.
    task automatic offer_beat(input logic [BW-1:0] d, input bit last, input bit hold,
                              output bit taken);
        in_valid = 1'b1;
        in_psum  = d;
        in_last  = last;
        taken    = (bus.psum_ready === 1'b1);
        if (taken) model_accept(d, last);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int n);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("out_valid_seen", bus.out_valid, 1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        beat_sums.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_psum_ready"}, bus.psum_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_overflow"}, bus.out_overflow, 0);
        check({tag, "_busy"}, busy_m, 0);
        check({tag, "_s20_data"}, bus_s20.out_data, 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && bus.out_valid === 1'b1 && out_ready) begin
            check("result_pending", exp_q.size() > 0, 1);
            check("s20_valid_aligned", bus_s20.out_valid, 1);
            check("w20_valid_aligned", bus_w20.out_valid, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data24", bus.out_data, e[66:43]);
                check("ovf24", bus.out_overflow, e[42]);
                check("data_sat20", bus_s20.out_data, e[41:22]);
                check("ovf_sat20", bus_s20.out_overflow, e[21]);
                check("data_wrap20", bus_w20.out_data, e[20:1]);
                check("ovf_wrap20", bus_w20.out_overflow, e[0]);
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        bit taken;
        int nb, r, mode, val;
        logic [BW-1:0] d;

        do_reset();
        check_reset_values("reset");

        // 1: single beat, all lanes 1
        out_ready = 1'b1;
        offer_beat(make_beat(0, 1), 1'b1, 1'b0, taken);
        check("t1_taken", taken, 1);
        check("t1_drain_ready", bus.psum_ready, 0);
        check("t1_drain_busy", busy_m, 1);
        wait_out_valid(n);
        check("t1_latency", n, 5);
        check("t1_data", bus.out_data, 9);
        tick();
        check("t1_back_to_accum", bus.psum_ready, 1);

        // 2: three beats with a gap cycle between the first two
        offer_beat(make_beat(0, 100), 1'b0, 1'b0, taken);
        tick();
        offer_beat(make_beat(0, 200), 1'b0, 1'b1, taken);
        offer_beat(make_beat(0, 300), 1'b1, 1'b0, taken);
        wait_out_valid(n);
        check("t2_latency", n, 5);
        check("t2_data", bus.out_data, 5400);
        tick();

        // 3: same pass, result held for 6 cycles with out_ready low
        out_ready = 1'b0;
        offer_beat(make_beat(0, 100), 1'b0, 1'b0, taken);
        tick();
        offer_beat(make_beat(0, 200), 1'b0, 1'b1, taken);
        offer_beat(make_beat(0, 300), 1'b1, 1'b0, taken);
        wait_out_valid(n);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_psum  = make_beat(0, 7);
            in_last  = 1'b1;
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_data", bus.out_data, 5400);
            check("t3_hold_ovf", bus.out_overflow, 0);
            check("t3_hold_ready", bus.psum_ready, 0);
            check("t3_hold_busy", busy_m, 1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t3_ready_after_accept", bus.psum_ready, 1);
        check("t3_valid_after_accept", bus.out_valid, 0);

        // 4: overflow of the 20-bit instances
        offer_beat(make_beat(0, 16'hFFFF), 1'b0, 1'b1, taken);
        offer_beat(make_beat(0, 16'hFFFF), 1'b1, 1'b0, taken);
        wait_out_valid(n);
        check("t4_sat20_data", bus_s20.out_data, 20'hFFFFF);
        check("t4_wrap20_data", bus_w20.out_data, 131054);
        check("t4_wrap20_ovf", bus_w20.out_overflow, 1);
        tick();

        // 5: reset in the middle of a pass
        offer_beat(make_beat(0, 3), 1'b0, 1'b1, taken);
        offer_beat(make_beat(0, 3), 1'b0, 1'b0, taken);
        rst = 1'b1;
        beat_sums.delete();
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        repeat (6) tick();
        check("t5_tree_flushed", bus.out_data, 0);
        check("t5_still_idle", busy_m, 0);
        offer_beat(make_beat(0, 2), 1'b1, 1'b0, taken);
        wait_out_valid(n);
        check("t5_data", bus.out_data, 18);
        tick();

        // 6: back-to-back random passes, psum_valid held high
        out_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                r = $urandom_range(0, 3);
                mode = (r == 0) ? 0 : ((r == 1) ? 1 : 2);
                val  = 16'hFFFF;
                d = make_beat(mode, val);
                taken = 1'b0;
                for (int t = 0; t < 20 && !taken; t++) begin
                    offer_beat(d, (b == nb - 1), 1'b1, taken);
                end
                check("t6_beat_accepted", taken, 1);
            end
        end
        in_valid = 1'b0;
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) tick();
        check("all_results_seen", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
